// File: rtl/fetch_pkg.sv
// fetch_pkg
// Types and constants shared by the instruction fetch stage and its
// two-entry output buffer.
//   INSTR_W / ADDR_W : instruction and byte-address widths
//   PC_STEP          : byte increment between sequential instructions
//   fetch_state_t    : RUN (fetching) / ERR (stopped until reset)
//   fetch_entry_t    : one buffered instruction together with its PC
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Two-entry FIFO between the fetch logic and decode. The head entry is
// presented combinationally; a flush empties the buffer in one edge.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   push_i, pop_i       : write the entry / drop the head (caller guarantees legality)
//   flush_i             : discard all entries; wins over push and pop
//   wr_instr_i, wr_pc_i : entry to write on push
//   head_instr_o        : instruction at the head
//   head_pc_o           : PC at the head
//   count_o             : number of valid entries (0..2)
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] wr_instr_i,
  input  logic [ADDR_W-1:0]  wr_pc_i,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [1:0]         count_o
);

  fetch_entry_t entries_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entries_q[0] <= '0;
      entries_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        if (push_i) begin
          entries_q[wr_ptr_q] <= '{instr: wr_instr_i, pc: wr_pc_i};
          wr_ptr_q            <= ~wr_ptr_q;
        end
        if (pop_i) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
    end
  end

  assign head_instr_o = entries_q[rd_ptr_q].instr;
  assign head_pc_o    = entries_q[rd_ptr_q].pc;
  assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Owns the PC, drives the instruction memory
// address, captures the returned word and hands {instr, pc} to decode
// through a valid/ready handshake backed by a two-entry buffer.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   imem_addr         : byte address to instruction memory (= PC register)
//   imem_rdata        : word returned combinationally for imem_addr
//   jump_en           : redirect request
//   jump_target       : redirect byte address
//   out_valid         : buffer head holds an instruction
//   out_ready         : decode accepts the head this cycle
//   out_instr, out_pc : buffer head instruction and its byte address
//   fetch_err         : sticky misaligned-target / PC-out-of-range flag
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fetch_err
);

  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(MEM_BYTES - 4);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;

  logic       push;
  logic       pop;
  logic       flush;
  logic [1:0] count;
  logic       can_push;
  logic       out_of_range;
  logic       misaligned;

  assign pop          = out_valid && out_ready;
  // A full buffer can still take a word when decode frees the head this edge.
  assign can_push     = (count != 2'd2) || pop;
  // Any wrap of pc+4 past 2^32 lands above PC_LAST first, so this also
  // catches wrap-around before it is ever used as a fetch address.
  assign out_of_range = pc_q > PC_LAST;
  assign misaligned   = jump_target[1:0] != 2'b00;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // Redirect outranks the range check, so a jump rescues an exhausted PC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (jump_en) begin
          if (misaligned) state_d = ERR;
        end else if (out_of_range) begin
          state_d = ERR;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    flush = 1'b0;
    if (state_q == RUN) begin
      if (jump_en) begin
        flush = 1'b1;
        if (misaligned) begin
          err_d = 1'b1;
        end else begin
          pc_d = jump_target;
        end
      end else if (out_of_range) begin
        err_d = 1'b1;
      end else if (can_push) begin
        push = 1'b1;
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (flush),
    .wr_instr_i   (imem_rdata),
    .wr_pc_i      (pc_q),
    .head_instr_o (out_instr),
    .head_pc_o    (out_pc),
    .count_o      (count)
  );

  assign imem_addr = pc_q;
  assign out_valid = count != 2'd0;
  assign fetch_err = err_q;

endmodule
